// File: rtl/oled_pkg.sv
// Shared OLED geometry and waveform-buffer FSM encoding for the display generators.
package oled_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_SWAP = 2'd1,
    SWAP      = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wave_bank_ram.sv
// Two-bank waveform store: one write port, one registered read port.
// Contents are never reset; the controller masks stale data instead.
module wave_bank_ram #(
  parameter int OLED_W = 96,
  parameter int DATA_W = 6,
  localparam int AW = $clog2(OLED_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2][OLED_W];

  // Write the back bank and register the front-bank read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/wave_buffer_ctrl.sv
// Double-buffered oscilloscope capture: decimated mic samples fill the back
// bank, a frame-aligned swap publishes it, and the OLED scan reads the front.
module wave_buffer_ctrl #(
  parameter int OLED_W = oled_pkg::OLED_W,
  parameter int OLED_H = oled_pkg::OLED_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_stb,
  input  logic [11:0] sample,
  input  logic [3:0]  decim,
  input  logic        freeze,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  output logic [5:0]  wave_y,
  output logic        valid_frame,
  output logic        capture_done,
  output logic        front_bank
);

  import oled_pkg::*;

  localparam int              AW       = $clog2(OLED_W);
  localparam logic [5:0]      Y_MAX    = 6'(OLED_H - 1);
  localparam logic [12:0]     N_PIX    = 13'(OLED_W * OLED_H);
  localparam logic [12:0]     W_PIX    = 13'(OLED_W);
  localparam logic [AW-1:0]   LAST_COL = AW'(OLED_W - 1);

  // Loud samples map to the top row; low bits are simply dropped.
  function automatic logic [5:0] sample_to_row(input logic [11:0] s);
    return Y_MAX - s[11:6];
  endfunction

  wb_state_t       state_q, state_d;
  logic [AW-1:0]   wr_ptr;
  logic [3:0]      dcnt;
  logic [3:0]      decim_l;
  logic            store;
  logic            last_store;
  logic            do_swap;
  logic [AW-1:0]   rd_col;
  logic [5:0]      rd_y_p1;
  logic            oor_p1;

  // Next-state logic and per-cycle write/swap decisions.
  always_comb begin
    state_d    = state_q;
    store      = 1'b0;
    last_store = 1'b0;
    do_swap    = 1'b0;
    case (state_q)
      FILL: begin
        if (sample_stb && (dcnt == 4'd0)) begin
          store = 1'b1;
          if (wr_ptr == LAST_COL) begin
            last_store = 1'b1;
            state_d    = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (frame_begin && !freeze) begin
          do_swap = 1'b1;
          state_d = SWAP;
        end
      end
      SWAP:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Write pointer, decimation counter, bank select and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      dcnt         <= '0;
      decim_l      <= '0;
      capture_done <= 1'b0;
      front_bank   <= 1'b0;
      valid_frame  <= 1'b0;
    end else begin
      capture_done <= last_store;
      if (store) begin
        wr_ptr <= last_store ? '0 : wr_ptr + 1'b1;
      end
      if ((state_q == FILL) && sample_stb) begin
        if (dcnt == 4'd0) begin
          decim_l <= decim;
          dcnt    <= (decim == 4'd0) ? 4'd0 : 4'd1;
        end else begin
          dcnt <= (dcnt >= decim_l) ? 4'd0 : dcnt + 4'd1;
        end
      end
      if (do_swap) begin
        front_bank  <= ~front_bank;
        valid_frame <= 1'b1;
      end
    end
  end

  assign rd_col = AW'(pixel_index % W_PIX);

  wave_bank_ram #(
    .OLED_W (OLED_W),
    .DATA_W (6)
  ) u_bank (
    .clk     (clk),
    .we      (store && !reset),
    .wr_bank (~front_bank),
    .wr_addr (wr_ptr),
    .wr_data (sample_to_row(sample)),
    .rd_bank (front_bank),
    .rd_addr (rd_col),
    .rd_data (rd_y_p1)
  );

  // p0 -> p1: out-of-range flag travels alongside the registered read.
  always_ff @(posedge clk) begin
    oor_p1 <= (pixel_index >= N_PIX);
  end

  assign wave_y = (valid_frame && !oor_p1) ? rd_y_p1 : Y_MAX;

endmodule

// File: doc/wave_buffer_ctrl.md
WAVE_BUFFER_CTRL -- requirements
Module: wave_buffer_ctrl

Interface
REQ-001 SHALL have parameter OLED_W, default 96, meaning the number of display columns and samples per buffer.
REQ-002 SHALL have parameter OLED_H, default 64, meaning the number of display rows (6-bit y range).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; it is the 6.25 MHz OLED pixel clock, and all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sample_stb, input, 1 bit: one-cycle pulse marking a new mic sample; it is synchronous to clk.
REQ-006 SHALL have port sample, input, 12 bits: audio sample, valid when sample_stb=1.
REQ-007 SHALL have port decim, input, 4 bits: store 1 of every decim+1 strobes.
REQ-008 SHALL have port freeze, input, 1 bit: level; when 1, buffer swaps are inhibited.
REQ-009 SHALL have port frame_begin, input, 1 bit: one-cycle pulse from the OLED driver at frame start.
REQ-010 SHALL have port pixel_index, input, 13 bits: current pixel index, 0..OLED_W*OLED_H-1.
REQ-011 SHALL have port wave_y, output, 6 bits: waveform row for the column of pixel_index.
REQ-012 SHALL have port valid_frame, output, 1 bit: high once the first buffer swap has completed.
REQ-013 SHALL have port capture_done, output, 1 bit: one-cycle pulse when the back buffer becomes full.
REQ-014 SHALL have port front_bank, output, 1 bit: index of the bank currently being displayed.

Function
REQ-015 SHALL hold two banks of OLED_W x 6-bit entries: the front bank is read and the back bank is written.
REQ-016 SHALL implement a decimation counter dcnt; an accepted strobe is stored when dcnt==0, and dcnt then counts 1..decim before wrapping to 0; a change to decim applies from the next wrap.
REQ-017 SHALL compute the stored value as OLED_H-1 minus sample[11:6] (loud = top row), truncating with no rounding.
REQ-018 SHALL implement FSM FILL -> WAIT_SWAP -> SWAP -> FILL.
REQ-019 In FILL, each stored sample SHALL be written to back[wr_ptr], after which wr_ptr increments.
REQ-020 A write at wr_ptr==OLED_W-1 SHALL wrap wr_ptr to 0, pulse capture_done on the next cycle, and move the FSM to WAIT_SWAP.
REQ-021 In WAIT_SWAP, sample_stb SHALL be ignored: no write occurs and dcnt does not advance.
REQ-022 WAIT_SWAP SHALL move to SWAP on frame_begin=1 with freeze=0; otherwise it stays in WAIT_SWAP.
REQ-023 SWAP SHALL last exactly one cycle: front_bank toggles, valid_frame is set to 1, and the FSM returns to FILL.
REQ-024 If frame_begin arrives in the same cycle as the last write, the swap SHALL NOT occur in that cycle; it waits for the next frame_begin.
REQ-025 A freeze rising edge while in FILL SHALL NOT stop filling; filling completes and the swap is deferred until freeze=0 coincides with frame_begin.
REQ-026 The displayed front bank SHALL change only on the cycle after a frame_begin, so there is no tearing within a frame.
REQ-027 The read column SHALL be x = pixel_index mod OLED_W.
REQ-028 wave_y SHALL be registered as front[x], one-cycle latency from pixel_index.
REQ-029 While valid_frame=0, wave_y SHALL equal OLED_H-1.
REQ-030 Out-of-range pixel_index (>= OLED_W*OLED_H) SHALL give wave_y = OLED_H-1.

Reset
REQ-031 On reset=1, FSM SHALL go to FILL, with wr_ptr=0, dcnt=0, front_bank=0, valid_frame=0, capture_done=0, and wave_y=OLED_H-1.
REQ-032 Bank contents SHALL NOT be reset; they are masked by valid_frame.
REQ-033 Reset asserted mid-fill or in WAIT_SWAP SHALL discard the partial or full back buffer.
REQ-034 Reset SHALL take priority over sample_stb and frame_begin in the same cycle.

Structure
REQ-035 OLED_W, OLED_H and the FSM state encoding SHALL reside in a shared package oled_pkg, for reuse by the display generators.
REQ-036 Bank storage SHALL be one sub-module wave_bank_ram (2 x OLED_W x 6, 1 write port, 1 registered read port); the FSM, counters and read mapping are in wave_buffer_ctrl.

Verification
REQ-037 Reset, decim=0, freeze=0, 96 strobes with sample=12'hFFF -> capture_done pulses after the 96th; the next frame_begin -> front_bank=1, valid_frame=1, wave_y=0 for all x.
REQ-038 decim=3, 384 strobes with sample=12'h000 -> exactly 96 writes, capture_done once, and after the swap wave_y=63 everywhere.
REQ-039 Back full, freeze=1, 3 frame_begin pulses -> no swap and front_bank unchanged; set freeze=0 and pulse frame_begin -> swap on the next cycle.
REQ-040 Last write and frame_begin in the same cycle -> no swap; the next frame_begin swaps.
REQ-041 reset pulsed at wr_ptr=50 -> wr_ptr=0, valid_frame=0, wave_y=63, and a refill requires 96 new stores.
REQ-042 After a swap with ramp data (sample = k<<6 at store k), pixel_index=96*5+10 -> wave_y=63-10=53 one cycle later; pixel_index=6144 -> wave_y=63.
